// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter and its latency counter.
// Holds the FSM/owner encodings and the width used by the small latency counter.
package core_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam int unsigned DEF_MEM_LAT    = 2;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // Both MEM_LAT and STARVE_MAX are limited to 1..15, so 4 bits covers them.
    localparam int unsigned CNT_W = 4;

    function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
// Used to time fixed-latency responses from multi-cycle units.
module arb_latency_counter
    import core_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement so a new transaction always restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access at a time.
// Data side has priority; a starvation counter forces a fetch win after STARVE_MAX losses.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output arb_state_e        dbg_state_o
);

    localparam logic [CNT_W-1:0] STARVE_LIM = to_cnt(STARVE_MAX);
    localparam logic [CNT_W-1:0] LAT_LOAD   = to_cnt(MEM_LAT - 1);

    arb_state_e       state_q;
    arb_owner_e       owner_q;
    logic             we_q;
    logic [CNT_W-1:0] starve_q;

    logic in_idle;
    logic if_forced;
    logic if_win;
    logic d_win;
    logic grant;
    logic lat_zero;
    logic resp;

    // Gating with reset keeps every strobe low while reset is held, even with requests up.
    assign in_idle   = reset && (state_q == ARB_IDLE);
    assign if_forced = if_req && (starve_q == STARVE_LIM);
    assign if_win    = in_idle && if_req && (!d_req || if_forced);
    assign d_win     = in_idle && d_req && !if_forced;
    assign grant     = if_win || d_win;
    assign resp      = reset && (state_q == ARB_WAIT) && lat_zero;

    arb_latency_counter #(
        .W(CNT_W)
    ) u_lat_cnt (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (grant),
        .load_val_i(LAT_LOAD),
        .dec_i     (state_q == ARB_WAIT),
        .zero_o    (lat_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant) begin
                        state_q <= ARB_WAIT;
                        owner_q <= d_win ? OWN_D : OWN_IF;
                        we_q    <= d_win && d_we;
                        // Only a data win over a waiting fetch counts as a lost arbitration.
                        if (d_win && if_req) begin
                            if (starve_q != STARVE_LIM) begin
                                starve_q <= starve_q + 1'b1;
                            end
                        end else begin
                            starve_q <= '0;
                        end
                    end
                end
                ARB_WAIT: begin
                    if (lat_zero) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_win;
    assign d_gnt     = d_win;
    assign mem_en    = grant;
    assign mem_we    = d_win && d_we;
    assign mem_addr  = d_win ? d_addr : (if_win ? if_addr : '0);
    assign mem_wdata = grant ? d_wdata : '0;

    // Response data is only driven towards the owner, and only in its rvalid cycle.
    assign if_rvalid = resp && (owner_q == OWN_IF);
    assign d_rvalid  = resp && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=1.
module tb_mem_port_arbiter;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // Instance 0 (MEM_LAT=2, STARVE_MAX=4)
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    arb_state_e  dbg_state;

    // Instance 1 (MEM_LAT=1)
    logic        if_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
    logic [31:0] if_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
    logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    arb_state_e  dbg_state1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .dbg_state_o(dbg_state1)
    );

    // Memory model: unwritten locations read back as {~addr[15:0], addr[15:0]}.
    logic [31:0] mem [logic [31:0]];
    logic [1:0][31:0] pipe0 = '0;
    logic [31:0] rdata1_q = '0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    always @(posedge clk) begin
        pipe0[1] <= pipe0[0];
        pipe0[0] <= mem_en ? rd_model(mem_addr) : 32'h0;
        rdata1_q <= mem_en1 ? dflt(mem_addr1) : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end

    assign mem_rdata  = pipe0[1];
    assign mem_rdata1 = rdata1_q;

    task automatic test_reset();
        d_req = 1'b1;
        if_req = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b exp 000000", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h exp 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        n_checks++;
        if (dbg_state !== ARB_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d exp %0d", dbg_state, ARB_IDLE);
        end
        d_req = 1'b0;
        if_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        if_req = 1'b1;
        if_addr = 32'h10;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 32'h10}) begin
            n_err++;
            $display("FAIL fetch_grant: got gnt=%b dgnt=%b en=%b we=%b addr=%h exp 1,0,1,0,10",
                     if_gnt, d_gnt, mem_en, mem_we, mem_addr);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_gnt, mem_en} !== 3'b000) begin
            n_err++;
            $display("FAIL fetch_wait: got rv=%b gnt=%b en=%b exp 000", if_rvalid, if_gnt, mem_en);
        end
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h00500093}) begin
            n_err++;
            $display("FAIL fetch_rdata: got rv=%b data=%h exp 1 00500093", if_rvalid, if_rdata);
        end
        n_checks++;
        if ({d_rvalid, d_rdata, d_gnt} !== 34'h0) begin
            n_err++;
            $display("FAIL fetch_no_d: got rv=%b data=%h gnt=%b exp 0", d_rvalid, d_rdata, d_gnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h40;
        d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 32'h40, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL store_grant: got gnt=%b en=%b we=%b addr=%h wd=%h exp 1,1,1,40,deadbeef",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL store_ack: got rv=%b data=%h ifrv=%b exp 1 0 0", d_rvalid, d_rdata, if_rvalid);
        end
        @(posedge clk);
        #1;
        d_req = 1'b1;
        d_we = 1'b0;
        d_wdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({d_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 32'h40}) begin
            n_err++;
            $display("FAIL load_grant: got gnt=%b en=%b we=%b addr=%h exp 1,1,0,40", d_gnt, mem_en, mem_we, mem_addr);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL load_rdata: got rv=%b data=%h exp 1 deadbeef", d_rvalid, d_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_starvation();
        logic exp_if [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int n = 0;
        int last = 0;
        logic [31:0] own;
        if_req = 1'b1;
        if_addr = 32'h200;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h100;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL starve_rvalid: got unexpected rvalid at cycle %0d exp none", cyc);
                end else begin
                    own = exp_q.pop_front();
                    if ({if_rvalid, d_rvalid} !== {own[0], ~own[0]}) begin
                        n_err++;
                        $display("FAIL starve_owner: got ifrv=%b drv=%b exp ifrv=%b", if_rvalid, d_rvalid, own[0]);
                    end
                end
                n_checks++;
                if (if_gnt || d_gnt) begin
                    n_err++;
                    $display("FAIL starve_overlap: got gnt with rvalid at cycle %0d exp no gnt", cyc);
                end
            end
            if (if_gnt || d_gnt) begin
                n_checks++;
                if ({if_gnt, d_gnt} !== {exp_if[n], ~exp_if[n]}) begin
                    n_err++;
                    $display("FAIL starve_order: grant %0d got if=%b d=%b exp if=%b", n, if_gnt, d_gnt, exp_if[n]);
                end
                if (n > 0) begin
                    n_checks++;
                    if (cyc - last != 3) begin
                        n_err++;
                        $display("FAIL starve_spacing: grant %0d got %0d cycles exp 3", n, cyc - last);
                    end
                end
                exp_q.push_back({31'h0, if_gnt});
                last = cyc;
                n++;
            end
        end
        n_checks++;
        if (n != 10) begin
            n_err++;
            $display("FAIL starve_count: got %0d grants exp 10", n);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic test_req_during_wait();
        if_req = 1'b1;
        if_addr = 32'h20;
        @(negedge clk);
        n_checks++;
        if (if_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL wait_first_gnt: got %b exp 1", if_gnt);
        end
        @(posedge clk);
        #1;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h44;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, mem_en} !== 3'b000) begin
            n_err++;
            $display("FAIL wait_no_gnt1: got if=%b d=%b en=%b exp 000", if_gnt, d_gnt, mem_en);
        end
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata, if_gnt, d_gnt} !== {1'b1, 32'hFFDF0020, 2'b00}) begin
            n_err++;
            $display("FAIL wait_rvalid: got rv=%b data=%h if=%b d=%b exp 1 ffdf0020 0 0",
                     if_rvalid, if_rdata, if_gnt, d_gnt);
        end
        @(negedge clk);
        n_checks++;
        if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 32'h44}) begin
            n_err++;
            $display("FAIL wait_d_wins: got d=%b if=%b addr=%h exp 1 0 44", d_gnt, if_gnt, mem_addr);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h80;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rst_first_gnt: got %b exp 1", d_gnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        if_req = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid, mem_addr} !== 37'h0) begin
            n_err++;
            $display("FAIL rst_immediate: got if=%b d=%b en=%b ifrv=%b drv=%b addr=%h exp all 0",
                     if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid, mem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({d_rvalid, if_rvalid, d_gnt, if_gnt, mem_en} !== 5'b0) begin
                n_err++;
                $display("FAIL rst_held_%0d: got drv=%b ifrv=%b d=%b if=%b en=%b exp 0",
                         k, d_rvalid, if_rvalid, d_gnt, if_gnt, mem_en);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 32'h80}) begin
            n_err++;
            $display("FAIL rst_release_gnt: got d=%b if=%b addr=%h exp 1 0 80", d_gnt, if_gnt, mem_addr);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_new_early: got %b exp 0", d_rvalid);
        end
        @(negedge clk);
        n_checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hFF7F0080}) begin
            n_err++;
            $display("FAIL rst_new_rdata: got rv=%b data=%h exp 1 ff7f0080", d_rvalid, d_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_lat1();
        logic [31:0] exp_d;
        if_req1 = 1'b1;
        if_addr1 = 32'h300;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({if_gnt1, if_rvalid1} !== {(k % 2 == 0), (k % 2 == 1)}) begin
                n_err++;
                $display("FAIL lat1_pattern_%0d: got gnt=%b rv=%b exp gnt=%b", k, if_gnt1, if_rvalid1, (k % 2 == 0));
            end
            if (if_gnt1) exp_q.push_back(dflt(if_addr1));
            if (if_rvalid1) begin
                n_checks++;
                exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
                if (if_rdata1 !== exp_d) begin
                    n_err++;
                    $display("FAIL lat1_rdata_%0d: got %h exp %h", k, if_rdata1, exp_d);
                end
            end
            @(posedge clk);
            #1;
            if (k % 2 == 0) if_addr1 = if_addr1 + 32'd4;
            if (k == 7) if_req1 = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({if_gnt1, if_rvalid1, mem_en1} !== 3'b000) begin
            n_err++;
            $display("FAIL lat1_idle: got gnt=%b rv=%b en=%b exp 000", if_gnt1, if_rvalid1, mem_en1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[32'h10] = 32'h00500093;
        test_reset();
        test_fetch();
        test_store_load();
        test_starvation();
        test_req_during_wait();
        test_reset_mid_wait();
        test_back_to_back_lat1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
